xor_stream_cipher: RTL and testbench

Parametrised serial XOR cipher core: deserialises a KEY_BITS key and a MSG_BITS message from one serial input, encrypts it one key-width chunk per cycle with either a repeating or a rotating key, then serialises the ciphertext MSB-first with a qualifying flag. It is the generalised successor of the fixed 8-bit-key / 64-bit-message XOR top. It sits between the chip's serial pins and the downstream receiving device.

---
 rtl/xor_stream_cipher_if.sv | 29 ++
 rtl/xor_stream_cipher.sv | 141 ++++++++++++++
 tb/tb_xor_stream_cipher.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xor_stream_cipher_if.sv
// Pin bundle of the serial XOR cipher: load/enable controls in, ciphertext stream and status out.
// oSerial_flag qualifies oSerial_out: the receiver takes one bit on every rising edge where the
// flag is high, there is no backpressure, and iEn low freezes the stream with both held.
interface xor_stream_cipher_if;
  logic       iEn;
  logic       iSerial_in;
  logic       iLoad_key;
  logic       iLoad_msg;
  logic       iMode;
  logic       oKey_full;
  logic       oMsg_full;
  logic       oBusy;
  logic       encryption_status;
  logic       oSerial_out;
  logic       oSerial_flag;
  logic [1:0] o_dbg_state;

  modport master (
    output iEn, iSerial_in, iLoad_key, iLoad_msg, iMode,
    input  oKey_full, oMsg_full, oBusy, encryption_status, oSerial_out, oSerial_flag,
    input  o_dbg_state
  );

  modport slave (
    input  iEn, iSerial_in, iLoad_key, iLoad_msg, iMode,
    output oKey_full, oMsg_full, oBusy, encryption_status, oSerial_out, oSerial_flag,
    output o_dbg_state
  );
endinterface

// File: rtl/xor_stream_cipher.sv
// Serial XOR cipher: shifts in a key and a message, XORs one key-width chunk per cycle
// (repeating or rotating key), then streams the ciphertext out MSB first.
module xor_stream_cipher #(
  parameter int MSG_BITS = 64,
  parameter int KEY_BITS = 8
) (
  input  logic                  iClk,
  input  logic                  iRst,
  xor_stream_cipher_if.slave    bus
);
  localparam int N   = MSG_BITS / KEY_BITS;
  localparam int KCW = $clog2(KEY_BITS + 1);
  localparam int MCW = $clog2(MSG_BITS + 1);
  localparam int CHW = (N > 1) ? $clog2(N) : 1;
  localparam int BW  = $clog2(MSG_BITS);
  localparam logic [KCW-1:0] KEY_FULL = KCW'(KEY_BITS);
  localparam logic [MCW-1:0] MSG_FULL = MCW'(MSG_BITS);

  typedef enum logic [1:0] {IDLE, ENCRYPT, SHIFT_OUT, DONE} state_t;

  state_t              r_state, w_state_nx;
  logic [KEY_BITS-1:0] r_key, r_wkey;
  logic [MSG_BITS-1:0] r_msg, r_ct;
  logic [KCW-1:0]      r_key_cnt;
  logic [MCW-1:0]      r_msg_cnt;
  logic [CHW-1:0]      r_chunk;
  logic [BW-1:0]       r_bit;
  logic                r_mode, r_key_full, r_msg_full, r_busy, r_status, r_sout, r_flag;

  logic                w_last_chunk, w_last_bit;
  logic [KEY_BITS-1:0] w_chunk_ct;
  logic [MSG_BITS-1:0] w_ct_enc;

  assign w_last_chunk = (r_chunk == CHW'(N - 1));
  assign w_last_bit   = (r_bit == BW'(MSG_BITS - 1));
  // The top chunk is encrypted and rotated into the bottom, so after N steps r_ct is in order.
  assign w_chunk_ct   = r_ct[MSG_BITS-1 -: KEY_BITS] ^ r_wkey;
  assign w_ct_enc     = (r_ct << KEY_BITS) | MSG_BITS'(w_chunk_ct);

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE:      if (r_key_full && r_msg_full) w_state_nx = ENCRYPT;
      ENCRYPT:   if (w_last_chunk)             w_state_nx = SHIFT_OUT;
      SHIFT_OUT: if (w_last_bit)               w_state_nx = DONE;
      DONE:                                    w_state_nx = IDLE;
      default:                                 w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst)          r_state <= IDLE;
    else if (bus.iEn)  r_state <= w_state_nx;
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_key      <= '0;
      r_wkey     <= '0;
      r_msg      <= '0;
      r_ct       <= '0;
      r_key_cnt  <= '0;
      r_msg_cnt  <= '0;
      r_chunk    <= '0;
      r_bit      <= '0;
      r_mode     <= 1'b0;
      r_key_full <= 1'b0;
      r_msg_full <= 1'b0;
      r_busy     <= 1'b0;
      r_status   <= 1'b0;
      r_sout     <= 1'b0;
      r_flag     <= 1'b0;
    end else if (bus.iEn) begin
      case (r_state)
        IDLE: begin
          // Key load wins when both load strobes are high; the message bit is dropped.
          if (bus.iLoad_key) begin
            if (r_key_cnt != KEY_FULL) begin
              r_key      <= {r_key[KEY_BITS-2:0], bus.iSerial_in};
              r_key_cnt  <= r_key_cnt + 1'b1;
              r_key_full <= (r_key_cnt == KEY_FULL - 1'b1);
            end
          end else if (bus.iLoad_msg) begin
            if (r_msg_cnt != MSG_FULL) begin
              r_msg      <= {r_msg[MSG_BITS-2:0], bus.iSerial_in};
              r_msg_cnt  <= r_msg_cnt + 1'b1;
              r_msg_full <= (r_msg_cnt == MSG_FULL - 1'b1);
            end
          end
          if (w_state_nx == ENCRYPT) begin
            r_ct    <= r_msg;
            r_wkey  <= r_key;
            r_mode  <= bus.iMode;
            r_chunk <= '0;
            r_busy  <= 1'b1;
          end
        end
        ENCRYPT: begin
          r_ct    <= w_ct_enc;
          r_chunk <= r_chunk + 1'b1;
          if (r_mode) r_wkey <= {r_wkey[KEY_BITS-2:0], r_wkey[KEY_BITS-1]};
          if (w_last_chunk) begin
            r_sout <= w_ct_enc[MSG_BITS-1];
            r_flag <= 1'b1;
            r_bit  <= '0;
          end
        end
        SHIFT_OUT: begin
          if (w_last_bit) begin
            r_sout   <= 1'b0;
            r_flag   <= 1'b0;
            r_busy   <= 1'b0;
            r_status <= 1'b1;
          end else begin
            r_ct   <= r_ct << 1;
            r_sout <= r_ct[MSG_BITS-2];
            r_bit  <= r_bit + 1'b1;
          end
        end
        DONE: begin
          r_status   <= 1'b0;
          r_key      <= '0;
          r_msg      <= '0;
          r_key_cnt  <= '0;
          r_msg_cnt  <= '0;
          r_key_full <= 1'b0;
          r_msg_full <= 1'b0;
        end
        default: r_status <= 1'b0;
      endcase
    end
  end

  assign bus.oKey_full         = r_key_full;
  assign bus.oMsg_full         = r_msg_full;
  assign bus.oBusy             = r_busy;
  assign bus.encryption_status = r_status;
  assign bus.oSerial_out       = r_sout;
  assign bus.oSerial_flag      = r_flag;
  assign bus.o_dbg_state       = r_state;
endmodule

// File: tb/tb_xor_stream_cipher.sv
// Bench for xor_stream_cipher: a 64/8 instance and a 32/16 instance share one stimulus bus;
// each scenario checks the selected instance's ciphertext stream against a chunk-level model.
module tb_xor_stream_cipher;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  xor_stream_cipher_if ifa ();
  xor_stream_cipher_if ifb ();

  xor_stream_cipher #(.MSG_BITS(64), .KEY_BITS(8))  dut_a (.iClk(clk), .iRst(rst), .bus(ifa.slave));
  xor_stream_cipher #(.MSG_BITS(32), .KEY_BITS(16)) dut_b (.iClk(clk), .iRst(rst), .bus(ifb.slave));

  logic en, sin, lk, lm, mode;
  assign ifa.iEn = en;  assign ifa.iSerial_in = sin;  assign ifa.iLoad_key = lk;
  assign ifa.iLoad_msg = lm;  assign ifa.iMode = mode;
  assign ifb.iEn = en;  assign ifb.iSerial_in = sin;  assign ifb.iLoad_key = lk;
  assign ifb.iLoad_msg = lm;  assign ifb.iMode = mode;

  bit   sel;
  logic o_flag, o_sout, o_busy, o_stat, o_kf, o_mf;
  always_comb begin
    o_flag = sel ? ifb.oSerial_flag      : ifa.oSerial_flag;
    o_sout = sel ? ifb.oSerial_out       : ifa.oSerial_out;
    o_busy = sel ? ifb.oBusy             : ifa.oBusy;
    o_stat = sel ? ifb.encryption_status : ifa.encryption_status;
    o_kf   = sel ? ifb.oKey_full         : ifa.oKey_full;
    o_mf   = sel ? ifb.oMsg_full         : ifa.oMsg_full;
  end

  int errors = 0;
  int checks = 0;
  logic [0:0] exp_q[$];

  // Reference: split the message into key-width chunks, XOR each with the key in force for
  // that chunk (the original key, or the key rotated left once per preceding chunk).
  function automatic logic [63:0] model(logic [63:0] msg, logic [63:0] key, bit md, int mb, int kb);
    logic [63:0] ct, k, kmask, chunk;
    ct = '0;
    kmask = (64'd1 << kb) - 64'd1;
    k = key & kmask;
    for (int c = 0; c < mb / kb; c++) begin
      chunk = (msg >> (mb - kb * (c + 1))) & kmask;
      ct = (ct << kb) | (chunk ^ k);
      if (md) k = ((k << 1) | (k >> (kb - 1))) & kmask;
    end
    return ct;
  endfunction

  task automatic load(logic [63:0] val, int nb, bit k, bit m);
    for (int i = nb - 1; i >= 0; i--) begin
      @(negedge clk);
      sin = val[i]; lk = k; lm = m;
    end
    @(negedge clk);
    lk = 1'b0; lm = 1'b0; sin = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Call right after the last load bit: the next edge starts the run.
  task automatic run_check(string name, logic [63:0] exp, int mb, int kb,
                           int stall_at, int rst_at, bit noise);
    int ecyc = 0;
    int got = 0;
    bit done = 0;
    logic [0:0] e = 1'b0;
    exp_q.delete();
    for (int i = mb - 1; i >= 0; i--) exp_q.push_back(exp[i]);
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      @(negedge clk);
      ecyc++;
      if (ecyc == 1) begin
        checks++;
        if (o_busy !== 1'b1) begin
          errors++; $display("FAIL %s busy_start: got %b want 1", name, o_busy);
        end
      end
      if (o_flag === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL %s extra_bit: flagged bit %0d beyond %0d", name, got, mb);
        end else begin
          e = exp_q.pop_front();
          if (o_sout !== e[0]) begin
            errors++; $display("FAIL %s bit%0d: got %b want %b", name, got, o_sout, e);
          end
        end
        got++;
        if (noise) begin
          lk = 1'b1; lm = 1'b1; sin = 1'($urandom); mode = 1'($urandom);
        end
        if (got - 1 == stall_at) begin
          en = 1'b0;
          repeat (5) begin
            @(negedge clk);
            checks++;
            if (o_flag !== 1'b1 || o_sout !== e[0]) begin
              errors++;
              $display("FAIL %s stall_hold: got flag=%b out=%b want flag=1 out=%b", name, o_flag, o_sout, e);
            end
          end
          en = 1'b1;
        end
        if (got - 1 == rst_at) begin
          rst = 1'b1; lk = 1'b0; lm = 1'b0;
          @(negedge clk);
          rst = 1'b0;
          checks++;
          if ({o_flag, o_sout, o_busy, o_stat, o_kf, o_mf} !== 6'b0) begin
            errors++;
            $display("FAIL %s reset_mid: got flag,out,busy,stat,kf,mf=%b want 000000", name,
                     {o_flag, o_sout, o_busy, o_stat, o_kf, o_mf});
          end
          return;
        end
      end
      if (o_stat === 1'b1) begin
        lk = 1'b0; lm = 1'b0;
        checks++;
        if (ecyc != (mb / kb) + mb + 1 || o_busy !== 1'b0 || got != mb) begin
          errors++;
          $display("FAIL %s status_timing: got cyc=%0d busy=%b bits=%0d want cyc=%0d busy=0 bits=%0d",
                   name, ecyc, o_busy, got, (mb / kb) + mb + 1, mb);
        end
        @(negedge clk);
        checks++;
        if (o_stat !== 1'b0 || o_kf !== 1'b0 || o_mf !== 1'b0) begin
          errors++;
          $display("FAIL %s after_done: got stat=%b kf=%b mf=%b want 0 0 0", name, o_stat, o_kf, o_mf);
        end
        done = 1;
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s timeout: no status pulse, got %0d bits want %0d", name, got, mb);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({ifa.oKey_full, ifa.oMsg_full, ifa.oBusy, ifa.encryption_status, ifa.oSerial_out,
         ifa.oSerial_flag, ifa.o_dbg_state} !== 8'b0) begin
      errors++; $display("FAIL reset_a: got %b want 00000000", {ifa.oKey_full, ifa.oMsg_full,
        ifa.oBusy, ifa.encryption_status, ifa.oSerial_out, ifa.oSerial_flag, ifa.o_dbg_state});
    end
    checks++;
    if ({ifb.oKey_full, ifb.oMsg_full, ifb.oBusy, ifb.encryption_status, ifb.oSerial_out,
         ifb.oSerial_flag, ifb.o_dbg_state} !== 8'b0) begin
      errors++; $display("FAIL reset_b: got %b want 00000000", {ifb.oKey_full, ifb.oMsg_full,
        ifb.oBusy, ifb.encryption_status, ifb.oSerial_out, ifb.oSerial_flag, ifb.o_dbg_state});
    end
  endtask

  task automatic test_mode0();
    mode = 1'b0;
    load(64'hA5, 8, 1, 0);
    load(64'h0123456789ABCDEF, 64, 0, 1);
    run_check("mode0", 64'hA486E0C22C0E684A, 64, 8, -1, -1, 0);
  endtask

  task automatic test_mode1();
    mode = 1'b1;
    load(64'hA5, 8, 1, 0);
    load(64'h0, 64, 0, 1);
    run_check("mode1", 64'hA54B962D5AB469D2, 64, 8, -1, -1, 0);
  endtask

  task automatic test_random();
    logic [63:0] k, m;
    for (int t = 0; t < 3; t++) begin
      k = 64'($urandom_range(0, 255));
      m = {$urandom, $urandom};
      mode = 1'($urandom);
      load(k, 8, 1, 0);
      load(m, 64, 0, 1);
      run_check("random", model(m, k, mode, 64, 8), 64, 8, -1, -1, 0);
    end
  endtask

  task automatic test_both_flags();
    logic [63:0] k, m;
    do_reset();
    k = 64'($urandom_range(0, 255));
    m = {$urandom, $urandom};
    mode = 1'b0;
    load(k, 8, 1, 1);
    repeat (4) @(negedge clk);
    checks++;
    if (o_kf !== 1'b1 || o_mf !== 1'b0 || o_busy !== 1'b0) begin
      errors++; $display("FAIL both_flags: got kf=%b mf=%b busy=%b want 1 0 0", o_kf, o_mf, o_busy);
    end
    load(m, 64, 0, 1);
    run_check("both_flags_run", model(m, k, 0, 64, 8), 64, 8, -1, -1, 0);
  endtask

  task automatic test_overflow();
    logic [63:0] k, m;
    k = 64'($urandom_range(0, 255));
    m = {$urandom, $urandom};
    mode = 1'b1;
    load(m, 64, 0, 1);
    load(64'($urandom_range(0, 63)), 6, 0, 1);
    checks++;
    if (o_mf !== 1'b1 || o_kf !== 1'b0 || o_busy !== 1'b0) begin
      errors++; $display("FAIL overflow_flags: got mf=%b kf=%b busy=%b want 1 0 0", o_mf, o_kf, o_busy);
    end
    load(k, 8, 1, 0);
    run_check("overflow", model(m, k, 1, 64, 8), 64, 8, -1, -1, 0);
  endtask

  task automatic test_load_during_shift();
    logic [63:0] k, m, x;
    k = 64'($urandom_range(0, 255));
    m = {$urandom, $urandom};
    mode = 1'b0;
    load(k, 8, 1, 0);
    load(m, 64, 0, 1);
    x = model(m, k, 0, 64, 8);
    run_check("load_in_shift", x, 64, 8, -1, -1, 1);
    mode = 1'b1;
    load(k, 8, 1, 0);
    load(m, 64, 0, 1);
    run_check("after_noise", model(m, k, 1, 64, 8), 64, 8, -1, -1, 0);
  endtask

  task automatic test_stall();
    mode = 1'b0;
    load(64'hA5, 8, 1, 0);
    load(64'h0123456789ABCDEF, 64, 0, 1);
    run_check("stall", 64'hA486E0C22C0E684A, 64, 8, 20, -1, 0);
  endtask

  task automatic test_reset_mid();
    logic [63:0] k, m;
    mode = 1'b1;
    load(64'hA5, 8, 1, 0);
    load(64'h0, 64, 0, 1);
    run_check("reset_mid", 64'hA54B962D5AB469D2, 64, 8, -1, 30, 0);
    k = 64'($urandom_range(0, 255));
    m = {$urandom, $urandom};
    load(k, 8, 1, 0);
    load(m, 64, 0, 1);
    run_check("after_reset", model(m, k, 1, 64, 8), 64, 8, -1, -1, 0);
  endtask

  task automatic test_sweep();
    sel = 1'b1;
    do_reset();
    mode = 1'b0;
    load(64'h1234, 16, 1, 0);
    load(64'hFFFF0000, 32, 0, 1);
    run_check("sweep_mode0", 64'hEDCB1234, 32, 16, -1, -1, 0);
    mode = 1'b1;
    load(64'h1234, 16, 1, 0);
    load(64'hFFFF0000, 32, 0, 1);
    run_check("sweep_mode1", 64'hEDCB2468, 32, 16, -1, -1, 0);
    sel = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; sin = 1'b0; lk = 1'b0; lm = 1'b0; mode = 1'b0; sel = 1'b0;
    test_reset();
    test_mode0();
    test_mode1();
    test_random();
    test_both_flags();
    test_overflow();
    test_load_during_shift();
    test_stall();
    test_reset_mid();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
